// File: rtl/ft_pkg.sv
// Shared state encoding and default sizing for the FT232H sync-FIFO bus scheduler.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OE,
        ST_RD,
        ST_WR,
        ST_TURN
    } state_t;

    localparam int unsigned DEF_RD_BURST_MAX = 64;
    localparam int unsigned DEF_WR_BURST_MAX = 64;
    localparam int unsigned DEF_TURNAROUND   = 1;

endpackage

// File: rtl/ft_bus_sched.sv
// FT232H synchronous-FIFO bus scheduler: alternates bounded read/write bursts
// with a fixed idle turnaround between them, and counts bytes per direction.
module ft_bus_sched
    import ft_pkg::*;
#(
    parameter int unsigned RD_BURST_MAX = DEF_RD_BURST_MAX,
    parameter int unsigned WR_BURST_MAX = DEF_WR_BURST_MAX,
    parameter int unsigned TURNAROUND   = DEF_TURNAROUND
) (
    input  logic        ft_clk,
    input  logic        rst_n,
    input  logic        ft_rxf_n,
    input  logic        ft_txe_n,
    output logic        ft_oe_n,
    output logic        ft_rd_n,
    output logic        ft_wr_n,
    input  logic [7:0]  ft_data_i,
    output logic [7:0]  ft_data_o,
    output logic        ft_data_oe,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_byte_cnt,
    output logic [31:0] tx_byte_cnt
);

    localparam logic [15:0] RD_MAX    = 16'(RD_BURST_MAX);
    localparam logic [15:0] WR_MAX    = 16'(WR_BURST_MAX);
    localparam logic [3:0]  TURN_LAST = 4'(TURNAROUND - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] burst_cnt;
    logic [3:0]  turn_cnt;
    logic        last_rd;
    logic        rq_rd;
    logic        rq_wr;
    logic        rd_xfer;
    logic        wr_xfer;

    always_comb begin
        rq_rd   = ~ft_rxf_n & rx_ready;
        rq_wr   = ~ft_txe_n & tx_valid;
        rd_xfer = (state == ST_RD) & rx_ready & ~ft_rxf_n;
        wr_xfer = (state == ST_WR) & tx_valid & ~ft_txe_n;

        state_nx   = state;
        ft_oe_n    = ~((state == ST_RD_OE) | (state == ST_RD));
        ft_rd_n    = ~((state == ST_RD) & rx_ready);
        tx_ready   = wr_xfer;
        ft_wr_n    = ~wr_xfer;
        ft_data_oe = (state == ST_WR);
        ft_data_o  = tx_data;

        case (state)
            // On contention the direction not served last wins; last_rd starts as write.
            ST_IDLE: begin
                if (rq_rd && (!rq_wr || !last_rd))
                    state_nx = ST_RD_OE;
                else if (rq_wr)
                    state_nx = ST_WR;
            end
            ST_RD_OE: state_nx = ST_RD;
            ST_RD: begin
                if (!rd_xfer || (burst_cnt + 16'd1 == RD_MAX))
                    state_nx = ST_TURN;
            end
            ST_WR: begin
                if (!wr_xfer || (burst_cnt + 16'd1 == WR_MAX))
                    state_nx = ST_TURN;
            end
            ST_TURN: begin
                if (turn_cnt == TURN_LAST)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ft_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            burst_cnt   <= '0;
            turn_cnt    <= '0;
            last_rd     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_byte_cnt <= '0;
            tx_byte_cnt <= '0;
        end else begin
            state    <= state_nx;
            rx_valid <= rd_xfer;
            if (rd_xfer) begin
                rx_data     <= ft_data_i;
                rx_byte_cnt <= rx_byte_cnt + 32'd1;
            end
            if (wr_xfer)
                tx_byte_cnt <= tx_byte_cnt + 32'd1;

            if (state == ST_IDLE)
                burst_cnt <= '0;
            else if (rd_xfer || wr_xfer)
                burst_cnt <= burst_cnt + 16'd1;

            if (state_nx == ST_TURN && state != ST_TURN) begin
                last_rd  <= (state == ST_RD);
                turn_cnt <= '0;
            end else if (state == ST_TURN) begin
                turn_cnt <= turn_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ft_bus_sched.sv
// Directed bench: FT232H host/sink/source models around three parameterisations.
module tb_ft_bus_sched;
    logic ft_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #8 ft_clk = ~ft_clk;

    logic [1:0] sel = 2'd0;
    logic       ft_txe_n = 1'b1;
    logic       rx_ready = 1'b1;
    logic       ft_rxf_n, tx_valid;
    logic [7:0] ft_data_i, tx_data;
    int         rd_idx = 0, rd_total = 0, tx_idx = 0, tx_total = 0;
    logic [7:0] rx_src [64];
    logic [7:0] tx_src [64];

    assign ft_rxf_n  = !(rd_idx < rd_total);
    assign ft_data_i = rx_src[rd_idx];
    assign tx_valid  = (tx_idx < tx_total);
    assign tx_data   = tx_src[tx_idx];

    logic [2:0]  oe_n_v, rd_n_v, wr_n_v, doe_v, rxv_v, txr_v;
    logic [7:0]  dout_v [3];
    logic [7:0]  rxd_v  [3];
    logic [31:0] rxc_v  [3];
    logic [31:0] txc_v  [3];

    ft_bus_sched u_def (
        .ft_clk(ft_clk), .rst_n(rst_n), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_oe_n(oe_n_v[0]), .ft_rd_n(rd_n_v[0]), .ft_wr_n(wr_n_v[0]),
        .ft_data_i(ft_data_i), .ft_data_o(dout_v[0]), .ft_data_oe(doe_v[0]),
        .rx_data(rxd_v[0]), .rx_valid(rxv_v[0]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_v[0]),
        .rx_byte_cnt(rxc_v[0]), .tx_byte_cnt(txc_v[0])
    );

    ft_bus_sched #(.RD_BURST_MAX(4), .WR_BURST_MAX(64), .TURNAROUND(2)) u_r4 (
        .ft_clk(ft_clk), .rst_n(rst_n), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_oe_n(oe_n_v[1]), .ft_rd_n(rd_n_v[1]), .ft_wr_n(wr_n_v[1]),
        .ft_data_i(ft_data_i), .ft_data_o(dout_v[1]), .ft_data_oe(doe_v[1]),
        .rx_data(rxd_v[1]), .rx_valid(rxv_v[1]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_v[1]),
        .rx_byte_cnt(rxc_v[1]), .tx_byte_cnt(txc_v[1])
    );

    ft_bus_sched #(.RD_BURST_MAX(8), .WR_BURST_MAX(8), .TURNAROUND(1)) u_b8 (
        .ft_clk(ft_clk), .rst_n(rst_n), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_oe_n(oe_n_v[2]), .ft_rd_n(rd_n_v[2]), .ft_wr_n(wr_n_v[2]),
        .ft_data_i(ft_data_i), .ft_data_o(dout_v[2]), .ft_data_oe(doe_v[2]),
        .rx_data(rxd_v[2]), .rx_valid(rxv_v[2]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_v[2]),
        .rx_byte_cnt(rxc_v[2]), .tx_byte_cnt(txc_v[2])
    );

    logic        oe_n, rd_n, wr_n, doe, rxv, txr;
    logic [7:0]  dout, rxd;
    logic [31:0] rxc, txc;
    assign oe_n = oe_n_v[sel];
    assign rd_n = rd_n_v[sel];
    assign wr_n = wr_n_v[sel];
    assign doe  = doe_v[sel];
    assign rxv  = rxv_v[sel];
    assign txr  = txr_v[sel];
    assign dout = dout_v[sel];
    assign rxd  = rxd_v[sel];
    assign rxc  = rxc_v[sel];
    assign txc  = txc_v[sel];

    int checks = 0, errors = 0;
    int runs[$];
    int gaps[$];
    logic [7:0] rx_got[$];
    logic [7:0] wr_got[$];
    int rd_oe_cnt = 0, overlap = 0, lat_err = 0, txr_cnt = 0;
    logic rd_last = 1'b0;

    // Bus-side model: transfers are recognised from strobes, indices advance after the edge.
    initial begin
        logic rd_x, wr_x;
        int cur, prev, len, gap, have_run;
        prev = 0; len = 0; gap = 0; have_run = 0;
        forever begin
            @(posedge ft_clk);
            rd_x = !oe_n && !rd_n && !ft_rxf_n;
            wr_x = !wr_n && !ft_txe_n;
            if (rd_x) rd_idx <= rd_idx + 1;
            if (wr_x) begin
                tx_idx <= tx_idx + 1;
                wr_got.push_back(dout);
            end
            if (txr) txr_cnt++;
            rd_last = rd_x;
            cur = rd_x ? 1 : (wr_x ? 2 : 0);
            if (!rst_n) begin
                prev = 0; len = 0; gap = 0; have_run = 0;
            end else begin
                if (cur == 0) gap++;
                if (cur != prev) begin
                    if (prev != 0) begin
                        runs.push_back(prev * 1000 + len);
                        have_run = 1;
                    end
                    if (cur != 0) begin
                        if (have_run != 0) gaps.push_back(gap);
                        gap = 0;
                        len = 1;
                    end
                end else if (cur != 0) begin
                    len++;
                end
                prev = cur;
            end
        end
    end

    initial begin
        logic prev_oe_n;
        prev_oe_n = 1'b1;
        forever begin
            @(negedge ft_clk);
            if (!oe_n && doe) overlap++;
            if (!oe_n && rd_n && prev_oe_n) rd_oe_cnt++;
            prev_oe_n = oe_n;
            if (rst_n && (rxv !== rd_last)) lat_err++;
            if (rxv) rx_got.push_back(rxd);
        end
    end

    task automatic do_reset(input logic [1:0] s);
        @(negedge ft_clk);
        rst_n = 1'b0;
        sel = s;
        ft_txe_n = 1'b1;
        rx_ready = 1'b1;
        rd_idx = 0; rd_total = 0; tx_idx = 0; tx_total = 0;
        @(negedge ft_clk);
        runs.delete(); gaps.delete(); rx_got.delete(); wr_got.delete();
        rd_oe_cnt = 0; overlap = 0; lat_err = 0; txr_cnt = 0;
    endtask

    task automatic load(input int nr, input int nt);
        for (int i = 0; i < 64; i++) begin
            rx_src[i] = 8'((i * 37 + 5) & 255);
            tx_src[i] = 8'((i * 53 + 200) & 255);
        end
        rd_total = nr;
        tx_total = nt;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((rd_idx < rd_total || tx_idx < tx_total) && n < 2000) begin
            @(negedge ft_clk);
            n++;
        end
        repeat (6) @(negedge ft_clk);
        checks++;
        if (rd_idx < rd_total || tx_idx < tx_total) begin
            errors++;
            $display("FAIL %s_timeout: rd %0d/%0d tx %0d/%0d", nm, rd_idx, rd_total, tx_idx, tx_total);
        end
    endtask

    task automatic test_reset();
        do_reset(2'd0);
        load(4, 4);
        ft_txe_n = 1'b0;
        #1;
        checks++;
        if ({oe_n, rd_n, wr_n, doe, txr, rxv} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 111000", {oe_n, rd_n, wr_n, doe, txr, rxv});
        end
        checks++;
        if (rxd !== 8'h00 || rxc !== 32'd0 || txc !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: rx_data %h rxc %0d txc %0d want 0", rxd, rxc, txc);
        end
        rst_n = 1'b1;
        @(negedge ft_clk);
        checks++;
        if (oe_n !== 1'b0 || rd_n !== 1'b1 || doe !== 1'b0 || rd_idx != 0) begin
            errors++;
            $display("FAIL reset_first_edge: oe_n %b rd_n %b doe %b rd_idx %0d want 0 1 0 0", oe_n, rd_n, doe, rd_idx);
        end
        wait_done("reset_prio");
        checks++;
        if (runs.size() != 2 || runs[0] != 1004 || runs[1] != 2004) begin
            errors++;
            $display("FAIL reset_prio_runs: got %p want '{1004,2004}", runs);
        end
    endtask

    task automatic test_rd_burst();
        do_reset(2'd0);
        load(10, 0);
        rst_n = 1'b1;
        wait_done("rd_burst");
        checks++;
        if (runs.size() != 1 || runs[0] != 1010) begin
            errors++;
            $display("FAIL rd_burst_runs: got %p want '{1010}", runs);
        end
        checks++;
        if (rd_oe_cnt != 1) begin
            errors++;
            $display("FAIL rd_burst_oe: got %0d RD_OE cycles want 1", rd_oe_cnt);
        end
        checks++;
        if (rx_got.size() != 10 || rxc !== 32'd10 || lat_err != 0) begin
            errors++;
            $display("FAIL rd_burst_cnt: valids %0d rxc %0d lat_err %0d want 10 10 0", rx_got.size(), rxc, lat_err);
        end
        for (int i = 0; i < rx_got.size() && i < 10; i++) begin
            checks++;
            if (rx_got[i] !== rx_src[i]) begin
                errors++;
                $display("FAIL rd_burst_data[%0d]: got %h want %h", i, rx_got[i], rx_src[i]);
            end
        end
    endtask

    task automatic test_rd_max();
        do_reset(2'd1);
        load(10, 0);
        rst_n = 1'b1;
        wait_done("rd_max");
        checks++;
        if (runs.size() != 3 || runs[0] != 1004 || runs[1] != 1004 || runs[2] != 1002) begin
            errors++;
            $display("FAIL rd_max_runs: got %p want '{1004,1004,1002}", runs);
        end
        checks++;
        if (gaps.size() != 2 || gaps[0] != 4 || gaps[1] != 4) begin
            errors++;
            $display("FAIL rd_max_gaps: got %p want '{4,4}", gaps);
        end
        checks++;
        if (rd_oe_cnt != 3 || rx_got.size() != 10 || rxc !== 32'd10) begin
            errors++;
            $display("FAIL rd_max_cnt: rd_oe %0d valids %0d rxc %0d want 3 10 10", rd_oe_cnt, rx_got.size(), rxc);
        end
        for (int i = 0; i < rx_got.size() && i < 10; i++) begin
            checks++;
            if (rx_got[i] !== rx_src[i]) begin
                errors++;
                $display("FAIL rd_max_data[%0d]: got %h want %h", i, rx_got[i], rx_src[i]);
            end
        end
    endtask

    task automatic test_alternate();
        do_reset(2'd2);
        load(16, 16);
        ft_txe_n = 1'b0;
        rst_n = 1'b1;
        wait_done("alternate");
        checks++;
        if (runs.size() != 4 || runs[0] != 1008 || runs[1] != 2008 || runs[2] != 1008 || runs[3] != 2008) begin
            errors++;
            $display("FAIL alt_runs: got %p want '{1008,2008,1008,2008}", runs);
        end
        checks++;
        if (gaps.size() != 3 || gaps[0] != 2 || gaps[1] != 3 || gaps[2] != 2) begin
            errors++;
            $display("FAIL alt_gaps: got %p want '{2,3,2}", gaps);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL alt_overlap: got %0d cycles want 0", overlap);
        end
        checks++;
        if (txc !== 32'd16 || rxc !== 32'd16 || txr_cnt != 16) begin
            errors++;
            $display("FAIL alt_cnt: txc %0d rxc %0d tx_ready %0d want 16 16 16", txc, rxc, txr_cnt);
        end
        for (int i = 0; i < wr_got.size() && i < 16; i++) begin
            checks++;
            if (wr_got[i] !== tx_src[i]) begin
                errors++;
                $display("FAIL alt_wdata[%0d]: got %h want %h", i, wr_got[i], tx_src[i]);
            end
        end
    endtask

    task automatic test_rx_stall();
        int n;
        do_reset(2'd0);
        load(20, 0);
        rst_n = 1'b1;
        n = 0;
        while (rd_idx < 5 && n < 200) begin
            @(negedge ft_clk);
            n++;
        end
        rx_ready = 1'b0;
        #1;
        checks++;
        if (rd_n !== 1'b1 || oe_n !== 1'b0 || rd_idx != 5) begin
            errors++;
            $display("FAIL stall_rd_n: rd_n %b oe_n %b rd_idx %0d want 1 0 5", rd_n, oe_n, rd_idx);
        end
        @(negedge ft_clk);
        checks++;
        if (oe_n !== 1'b1 || rd_idx != 5) begin
            errors++;
            $display("FAIL stall_exit: oe_n %b rd_idx %0d want 1 5", oe_n, rd_idx);
        end
        repeat (2) @(negedge ft_clk);
        rx_ready = 1'b1;
        wait_done("stall");
        checks++;
        if (runs.size() != 2 || runs[0] != 1005 || runs[1] != 1015) begin
            errors++;
            $display("FAIL stall_runs: got %p want '{1005,1015}", runs);
        end
        checks++;
        if (rx_got.size() != 20 || rxc !== 32'd20 || lat_err != 0) begin
            errors++;
            $display("FAIL stall_cnt: valids %0d rxc %0d lat_err %0d want 20 20 0", rx_got.size(), rxc, lat_err);
        end
        for (int i = 0; i < rx_got.size() && i < 20; i++) begin
            checks++;
            if (rx_got[i] !== rx_src[i]) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h want %h", i, rx_got[i], rx_src[i]);
            end
        end
    endtask

    task automatic test_wr();
        do_reset(2'd0);
        load(0, 5);
        ft_txe_n = 1'b0;
        rst_n = 1'b1;
        wait_done("wr");
        checks++;
        if (txr_cnt != 5 || txc !== 32'd5 || runs.size() != 1 || runs[0] != 2005) begin
            errors++;
            $display("FAIL wr_cnt: tx_ready %0d txc %0d runs %p want 5 5 '{2005}", txr_cnt, txc, runs);
        end
        for (int i = 0; i < wr_got.size() && i < 5; i++) begin
            checks++;
            if (wr_got[i] !== tx_src[i]) begin
                errors++;
                $display("FAIL wr_data[%0d]: got %h want %h", i, wr_got[i], tx_src[i]);
            end
        end
    endtask

    task automatic test_wr_reset();
        int n;
        do_reset(2'd0);
        load(0, 30);
        ft_txe_n = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (tx_idx < 3 && n < 200) begin
            @(negedge ft_clk);
            n++;
        end
        checks++;
        if (doe !== 1'b1 || txc !== 32'd3) begin
            errors++;
            $display("FAIL wr_reset_pre: doe %b txc %0d want 1 3", doe, txc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_n !== 1'b1 || doe !== 1'b0 || txr !== 1'b0 || oe_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_reset_strobes: wr_n %b doe %b tx_ready %b oe_n %b want 1 0 0 1", wr_n, doe, txr, oe_n);
        end
        checks++;
        if (txc !== 32'd0 || rxc !== 32'd0 || rxv !== 1'b0) begin
            errors++;
            $display("FAIL wr_reset_cnt: txc %0d rxc %0d rxv %b want 0 0 0", txc, rxc, rxv);
        end
        @(negedge ft_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge ft_clk);
    endtask

    initial begin
        test_reset();
        test_rd_burst();
        test_rd_max();
        test_alternate();
        test_rx_stall();
        test_wr();
        test_wr_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
